// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared arbiter state type and round-robin pointer helper for the cache/AXI path
package cache_axi_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int rr_next(input int ptr, input int n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority encoder, first set req at or above ptr with wrap-around
module rr_pick #(
  parameter int N = 2,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);
  logic [N-1:0] rot;
  logic [IDXW:0] sum;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    found = |rot;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) sum = {1'b0, ptr} + (IDXW + 1)'(k);
    idx = (sum >= (IDXW + 1)'(N)) ? IDXW'(sum - (IDXW + 1)'(N)) : IDXW'(sum);
  end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin packet-locking mux with a registered output stage
module rr_arb_mux #(
  parameter int N = 2,
  parameter int WIDTH = 32,
  localparam int IDXW = $clog2(N)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]      in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic [IDXW-1:0]   out_sel
);
  import cache_axi_pkg::*;
  arb_state_e state_q, state_d;
  logic [IDXW-1:0] ptr_q, gnt_q, pick, g;
  logic found, can_take, accept;
  rr_pick #(.N(N)) u_pick (.req(in_valid), .ptr(ptr_q), .found(found), .idx(pick));
  assign can_take = !out_valid || out_ready;
  assign g = (state_q == ARB_LOCKED) ? gnt_q : pick;
  // while locked the owner sees ready even if it has a bubble, so nobody else can sneak in
  assign in_ready = (resetn && can_take && (state_q == ARB_LOCKED || (found && in_valid[g]))) ? N'(1) << g : '0;
  assign accept = in_valid[g] && in_ready[g];
  always_comb begin
    state_d = state_q;
    if (accept) state_d = in_last[g] ? ARB_IDLE : ARB_LOCKED;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sel <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= in_data[int'(g)*WIDTH +: WIDTH];
        out_last <= in_last[g];
        out_sel <= g;
        if (!in_last[g]) gnt_q <= g;
        if (in_last[g]) ptr_q <= IDXW'(rr_next(int'(g), N));
      end else if (can_take) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed scenarios plus randomized traffic against a queue-based reference model
module tb_rr_arb_mux;
  localparam int W = 32;
  logic clk = 1'b0, resetn = 1'b1;
  logic [1:0] v2 = '0, l2 = '0, r2;
  logic [2*W-1:0] d2 = '0;
  logic or2 = 1'b1, ov2, ol2, os2;
  logic [W-1:0] od2;
  logic [3:0] v4 = '0, l4 = '0, r4;
  logic [4*W-1:0] d4 = '0;
  logic or4 = 1'b1, ov4, ol4;
  logic [1:0] os4;
  logic [W-1:0] od4;
  int runs = 0, fails = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.N(2), .WIDTH(W)) u2 (
    .clk(clk), .resetn(resetn), .in_valid(v2), .in_ready(r2), .in_data(d2), .in_last(l2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_last(ol2), .out_sel(os2));
  rr_arb_mux #(.N(4), .WIDTH(W)) u4 (
    .clk(clk), .resetn(resetn), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_last(ol4), .out_sel(os4));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    v2 = '0; l2 = '0; d2 = '0; or2 = 1'b1;
    v4 = '0; l4 = '0; d4 = '0; or4 = 1'b1;
    cyc;
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    #2 resetn = 1'b0;
    v2 = 2'b11; l2 = 2'b11; d2 = {32'hB0, 32'hA0};
    #1;
    runs++; if (r2 !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", r2); end
    runs++; if (ov2 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov2); end
    runs++; if (os2 !== 1'b0) begin fails++; $display("FAIL reset_out_sel: got %h want 0", os2); end
    runs++; if (od2 !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", od2); end
    cyc; cyc;
    runs++; if (ov2 !== 1'b0 || r2 !== 2'b00) begin fails++; $display("FAIL reset_held: got valid %b ready %b want 0 00", ov2, r2); end
    resetn = 1'b1;
    #1;
    runs++; if (r2 !== 2'b01) begin fails++; $display("FAIL reset_first_ready: got %b want 01", r2); end
    cyc;
    runs++; if (ov2 !== 1'b1 || os2 !== 1'b0 || od2 !== 32'hA0) begin fails++; $display("FAIL reset_first_grant: got v%b sel %h data %h want v1 sel 0 data a0", ov2, os2, od2); end
  endtask

  task automatic test_round_robin;
    int cnt[2];
    int exp_sel[4];
    exp_sel = '{0, 1, 0, 1};
    cnt = '{0, 0};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      v2 = 2'b11; l2 = 2'b11;
      d2 = {32'hB0 + 32'(cnt[1]), 32'hA0 + 32'(cnt[0])};
      #1;
      runs++; if (r2 !== 2'(1 << exp_sel[i])) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", i, r2, 2'(1 << exp_sel[i])); end
      cyc;
      runs++; if (os2 !== 1'(exp_sel[i])) begin fails++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, os2, exp_sel[i]); end
      runs++; if (od2 !== ((exp_sel[i] == 0 ? 32'hA0 : 32'hB0) + 32'(cnt[exp_sel[i]]))) begin fails++; $display("FAIL rr_data[%0d]: got %h want %h", i, od2, (exp_sel[i] == 0 ? 32'hA0 : 32'hB0) + 32'(cnt[exp_sel[i]])); end
      cnt[exp_sel[i]]++;
    end
  endtask

  task automatic test_lock;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      v2 = 2'b11; l2 = {1'b1, i == 3};
      d2 = {32'h20, 32'h10 + 32'(i)};
      #1;
      runs++; if (r2 !== 2'b01) begin fails++; $display("FAIL lock_ready[%0d]: got %b want 01", i, r2); end
      cyc;
      runs++; if (od2 !== 32'h10 + 32'(i) || os2 !== 1'b0) begin fails++; $display("FAIL lock_beat[%0d]: got %h sel %0d want %h sel 0", i, od2, os2, 32'h10 + 32'(i)); end
    end
    #1;
    runs++; if (r2 !== 2'b10) begin fails++; $display("FAIL lock_handover_ready: got %b want 10", r2); end
    cyc;
    runs++; if (od2 !== 32'h20 || os2 !== 1'b1 || ov2 !== 1'b1) begin fails++; $display("FAIL lock_handover: got %h sel %0d v%b want 20 sel 1 v1", od2, os2, ov2); end
    v2 = '0;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] hold;
    int sent, got;
    bit acc, stall;
    sent = 0; got = 0;
    do_reset;
    for (int t = 0; t < 40 && got < 6; t++) begin
      or2 = !(t >= 3 && t < 6);
      v2 = {1'b0, sent < 6};
      d2 = {32'h0, 32'h30 + 32'(sent)};
      l2 = {1'b0, sent == 5};
      #1;
      stall = ov2 && !or2;
      hold = od2;
      if (stall) begin
        runs++; if (r2 !== 2'b00) begin fails++; $display("FAIL bp_stall_ready[t%0d]: got %b want 00", t, r2); end
      end
      acc = v2[0] && r2[0];
      if (ov2 && or2) begin
        runs++;
        if (exp_q.size() == 0 || od2 !== exp_q[0]) begin fails++; $display("FAIL bp_data[t%0d]: got %h want %h", t, od2, exp_q.size() ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      cyc;
      if (acc) begin exp_q.push_back(32'h30 + 32'(sent)); sent++; end
      if (stall) begin
        runs++; if (od2 !== hold || ov2 !== 1'b1) begin fails++; $display("FAIL bp_hold[t%0d]: got %h v%b want %h v1", t, od2, ov2, hold); end
      end
    end
    or2 = 1'b1;
    runs++; if (got != 6 || sent != 6) begin fails++; $display("FAIL bp_count: got %0d rx %0d tx want 6 6", got, sent); end
  endtask

  task automatic test_bubble;
    do_reset;
    v2 = 2'b11; d2 = {32'h50, 32'h40}; l2 = 2'b10;
    #1;
    runs++; if (r2 !== 2'b01) begin fails++; $display("FAIL bub_first_ready: got %b want 01", r2); end
    cyc;
    runs++; if (od2 !== 32'h40 || os2 !== 1'b0) begin fails++; $display("FAIL bub_first: got %h sel %0d want 40 sel 0", od2, os2); end
    v2 = 2'b10;
    for (int i = 0; i < 2; i++) begin
      #1;
      runs++; if (r2 !== 2'b01) begin fails++; $display("FAIL bub_ready[%0d]: got %b want 01", i, r2); end
      cyc;
      runs++; if (ov2 !== 1'b0) begin fails++; $display("FAIL bub_drain[%0d]: got %b want 0", i, ov2); end
    end
    v2 = 2'b11; d2 = {32'h50, 32'h41}; l2 = 2'b11;
    #1;
    cyc;
    runs++; if (od2 !== 32'h41 || os2 !== 1'b0 || ol2 !== 1'b1) begin fails++; $display("FAIL bub_resume: got %h sel %0d last %b want 41 sel 0 last 1", od2, os2, ol2); end
    #1;
    runs++; if (r2 !== 2'b10) begin fails++; $display("FAIL bub_next_ready: got %b want 10", r2); end
    cyc;
    runs++; if (od2 !== 32'h50 || os2 !== 1'b1) begin fails++; $display("FAIL bub_next: got %h sel %0d want 50 sel 1", od2, os2); end
    v2 = '0;
  endtask

  task automatic test_wrap4;
    do_reset;
    v4 = 4'b0100; l4 = 4'b1111;
    d4 = {32'h63, 32'h62, 32'h61, 32'h60};
    #1;
    runs++; if (r4 !== 4'b0100) begin fails++; $display("FAIL wrap_pre_ready: got %b want 0100", r4); end
    cyc;
    runs++; if (os4 !== 2'd2 || od4 !== 32'h62) begin fails++; $display("FAIL wrap_pre: got sel %0d %h want 2 62", os4, od4); end
    v4 = 4'b1010;
    #1;
    runs++; if (r4 !== 4'b1000) begin fails++; $display("FAIL wrap_ready3: got %b want 1000", r4); end
    cyc;
    runs++; if (os4 !== 2'd3 || od4 !== 32'h63) begin fails++; $display("FAIL wrap_sel3: got sel %0d %h want 3 63", os4, od4); end
    #1;
    runs++; if (r4 !== 4'b0010) begin fails++; $display("FAIL wrap_ready1: got %b want 0010", r4); end
    cyc;
    runs++; if (os4 !== 2'd1 || od4 !== 32'h61) begin fails++; $display("FAIL wrap_sel1: got sel %0d %h want 1 61", os4, od4); end
    v4 = '0;
  endtask

  task automatic test_async_reset;
    do_reset;
    v2 = 2'b01; d2 = {32'h0, 32'h70}; l2 = 2'b01;
    cyc;
    v2 = 2'b10; d2 = {32'h71, 32'h0}; l2 = 2'b00;
    cyc;
    runs++; if (os2 !== 1'b1 || od2 !== 32'h71) begin fails++; $display("FAIL ar_setup: got sel %0d %h want 1 71", os2, od2); end
    #2 resetn = 1'b0;
    #1;
    runs++; if (ov2 !== 1'b0 || od2 !== '0 || r2 !== 2'b00) begin fails++; $display("FAIL ar_immediate: got v%b %h rdy %b want v0 0 00", ov2, od2, r2); end
    cyc;
    resetn = 1'b1;
    v2 = 2'b11; l2 = 2'b11; d2 = {32'h73, 32'h72};
    #1;
    runs++; if (r2 !== 2'b01) begin fails++; $display("FAIL ar_restart_ready: got %b want 01", r2); end
    cyc;
    runs++; if (os2 !== 1'b0 || od2 !== 32'h72) begin fails++; $display("FAIL ar_restart: got sel %0d %h want 0 72", os2, od2); end
    v2 = '0;
  endtask

  task automatic test_random;
    logic [W-1:0] qd[$];
    int qs[$];
    bit ql[$];
    int seq[2], rem[2];
    int owner, rrp, er, c;
    logic [1:0] acc;
    do_reset;
    owner = -1; rrp = 0; acc = '0;
    for (int k = 0; k < 2; k++) begin seq[k] = 0; rem[k] = $urandom_range(1, 4); end
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          seq[k]++; rem[k]--;
          if (rem[k] == 0) rem[k] = $urandom_range(1, 4);
        end
        v2[k] = $urandom_range(0, 3) != 0;
        d2[k*W +: W] = {8'(k), 24'(seq[k])};
        l2[k] = rem[k] == 1;
      end
      or2 = $urandom_range(0, 3) != 0;
      #1;
      er = 0;
      if (!(qs.size() != 0 && !or2)) begin
        if (owner >= 0) er = 1 << owner;
        else for (int k = 1; k >= 0; k--) if (v2[(rrp + k) % 2]) er = 1 << ((rrp + k) % 2);
      end
      runs++; if (r2 !== 2'(er)) begin fails++; $display("FAIL rnd_ready[t%0d]: got %b want %b", t, r2, 2'(er)); end
      acc = v2 & 2'(er);
      if (qs.size() != 0 && or2) begin void'(qd.pop_front()); void'(qs.pop_front()); void'(ql.pop_front()); end
      if (acc != 0) begin
        c = acc[1] ? 1 : 0;
        qd.push_back(d2[c*W +: W]); qs.push_back(c); ql.push_back(l2[c]);
        if (l2[c]) begin owner = -1; rrp = (c + 1) % 2; end else owner = c;
      end
      cyc;
      runs++; if (ov2 !== (qs.size() != 0)) begin fails++; $display("FAIL rnd_valid[t%0d]: got %b want %b", t, ov2, qs.size() != 0); end
      if (qs.size() != 0) begin
        runs++;
        if (od2 !== qd[0] || os2 !== 1'(qs[0]) || ol2 !== ql[0]) begin fails++; $display("FAIL rnd_beat[t%0d]: got %h sel %0d last %b want %h sel %0d last %b", t, od2, os2, ol2, qd[0], qs[0], ql[0]); end
      end
    end
    v2 = '0; or2 = 1'b1;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_lock;
    test_backpressure;
    test_bubble;
    test_wrap4;
    test_async_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
